// File: rtl/csram_arbiter.sv
// csram_arbiter
//
// Two-port arbiter/sequencer for the shared 16-bit combinational csram.
// Each accepted request is captured in IDLE, driven onto the memory for
// exactly one ACCESS cycle, and acknowledged with a one-cycle pulse in DONE.
// The block is the only driver of the memory's address, data and enables.
//
// Ports:
//   clk, reset_n             - clock; synchronous active-low reset
//   req0/we0/addr0/wdata0    - port 0 request (held stable until ack0)
//   ack0, rdata0             - port 0 completion pulse and result
//   req1/we1/addr1/wdata1    - port 1 request (held stable until ack1)
//   ack1, rdata1             - port 1 completion pulse and result
//   busy                     - high whenever the sequencer is not idle
//   sram_address/sram_data   - memory address and write data
//   sram_write_enable        - memory write strobe
//   sram_output_enable       - memory read enable
//   sram_rdata               - memory read data (combinational echo)
//
// Build option:
//   CSRAM_ARBITER_ROUND_ROBIN_EN - defined: contention alternates between
//   ports using a 1-bit last-grant pointer (port 0 wins first after reset).
//   Undefined: fixed priority, port 0 always wins contention.

module csram_arbiter (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        req0,
  input  logic        we0,
  input  logic [15:0] addr0,
  input  logic [15:0] wdata0,
  output logic        ack0,
  output logic [15:0] rdata0,

  input  logic        req1,
  input  logic        we1,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata1,
  output logic        ack1,
  output logic [15:0] rdata1,

  output logic        busy,

  output logic [15:0] sram_address,
  output logic [15:0] sram_data,
  output logic        sram_write_enable,
  output logic        sram_output_enable,
  input  logic [15:0] sram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;

  // Captured transaction
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        port_q, port_d;

  // Per-port result registers
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;

  // Arbitration result for the current IDLE cycle
  logic        grant_valid;
  logic        grant_port;

`ifdef CSRAM_ARBITER_ROUND_ROBIN_EN
  // Last granted port; resets to 1 so port 0 wins the first contention.
  logic        last_q, last_d;
`endif

  // --------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------
  always_comb begin
    grant_valid = req0 | req1;
`ifdef CSRAM_ARBITER_ROUND_ROBIN_EN
    if (req0 && req1) begin
      grant_port = ~last_q;
    end else if (req0) begin
      grant_port = 1'b0;
    end else begin
      grant_port = 1'b1;
    end
`else
    grant_port = ~req0;
`endif
  end

  // --------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------
  always_comb begin
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    port_d   = port_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef CSRAM_ARBITER_ROUND_ROBIN_EN
    last_d   = last_q;
`endif

    if (state_q == ST_IDLE && grant_valid) begin
      port_d  = grant_port;
      we_d    = grant_port ? we1    : we0;
      addr_d  = grant_port ? addr1  : addr0;
      wdata_d = grant_port ? wdata1 : wdata0;
`ifdef CSRAM_ARBITER_ROUND_ROBIN_EN
      last_d  = grant_port;
`endif
    end

    // The memory is combinational: its output is valid in the same cycle
    // the address is driven, and it echoes the data on writes.
    if (state_q == ST_ACCESS) begin
      if (port_q) begin
        rdata1_d = sram_rdata;
      end else begin
        rdata0_d = sram_rdata;
      end
    end
  end

  // --------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      port_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      port_q   <= port_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

`ifdef CSRAM_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // --------------------------------------------------------------------
  // FSM: outputs, decoded from registered state only
  // --------------------------------------------------------------------
  always_comb begin
    busy               = (state_q != ST_IDLE);
    ack0               = (state_q == ST_DONE) && !port_q;
    ack1               = (state_q == ST_DONE) &&  port_q;
    sram_address       = '0;
    sram_data          = '0;
    sram_write_enable  = 1'b0;
    sram_output_enable = 1'b0;
    if (state_q == ST_ACCESS) begin
      sram_address       = addr_q;
      sram_write_enable  = we_q;
      sram_output_enable = ~we_q;
      sram_data          = we_q ? wdata_q : '0;
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule
